// File: rtl/xy_symbol_tx_if.sv
// Frame-load and symbol-stream bundle for xy_symbol_tx.
// The source drives load/data, and the transmitter drives the symbol outputs and flags.
interface xy_symbol_tx_if #(
    parameter int NSYM = 4
);
    logic                load;
    logic [2*NSYM-1:0]   data;
    logic                ready;
    logic                x;
    logic                y;
    logic                valid;
    logic                done;

    modport master (output load, data, input ready, x, y, valid, done);
    modport slave  (input load, data, output ready, x, y, valid, done);
endinterface

// File: rtl/xy_symbol_tx.sv
// Serialises a 2*NSYM-bit word onto the x/y wires, MSB pair first.
// Each symbol is held for HOLD cycles and is framed by the valid and done flags.
module xy_symbol_tx #(
    parameter int HOLD = 2,
    parameter int NSYM = 4
) (
    input  logic               clk,
    input  logic               rst,
    xy_symbol_tx_if.slave      bus,
    output logic [1:0]         dbg_state_o
);
    localparam int DW = 2 * NSYM;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int SW = (NSYM > 0) ? (($clog2(NSYM + 1) > 0) ? $clog2(NSYM + 1) : 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic [DW-1:0]   shreg_q;
    logic [DW-1:0]   shifted_d;
    logic [HW-1:0]   hold_q;
    logic [SW-1:0]   sym_q;
    logic            ready_q;
    logic            valid_q;
    logic            done_q;
    logic            x_q;
    logic            y_q;

    // The head of the register is always the symbol on the wires; the next symbol is taken after shifting.
    assign shifted_d = shreg_q << 2;

    // Handshake: a frame starts on any rising edge where ready=1 and load=1.
    // valid=1 marks each cycle in which x/y carry a frame symbol.
    // load is ignored while ready=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            hold_q  <= '0;
            sym_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.load) begin
                        state_q <= ST_SEND;
                        shreg_q <= bus.data;
                        hold_q  <= '0;
                        sym_q   <= '0;
                        ready_q <= 1'b0;
                        valid_q <= 1'b1;
                        x_q     <= bus.data[DW-1];
                        y_q     <= bus.data[DW-2];
                    end else begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                        x_q     <= 1'b0;
                        y_q     <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (hold_q == HW'(HOLD - 1)) begin
                        hold_q <= '0;
                        if (sym_q == SW'(NSYM - 1)) begin
                            state_q <= ST_DONE;
                            shreg_q <= '0;
                            sym_q   <= '0;
                            ready_q <= 1'b1;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            x_q     <= 1'b0;
                            y_q     <= 1'b0;
                        end else begin
                            shreg_q <= shifted_d;
                            sym_q   <= sym_q + 1'b1;
                            x_q     <= shifted_d[DW-1];
                            y_q     <= shifted_d[DW-2];
                        end
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    x_q     <= 1'b0;
                    y_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready   = ready_q;
    assign bus.valid   = valid_q;
    assign bus.done    = done_q;
    assign bus.x       = x_q;
    assign bus.y       = y_q;
    assign dbg_state_o = state_q;
endmodule

// File: doc/xy_symbol_tx.md
# xy_symbol_tx

Frame transmitter that drives the two-wire `x`/`y` symbol stream consumed by the lab1 `x,y → z` logic, replacing hand-written testbench stimulus with a synthesizable source. A parallel word of `2*NSYM` bits is loaded with a handshake. It is then shifted out as `NSYM` two-bit symbols, MSB pair first, each held for `HOLD` clock cycles. Framing flags (`valid`, `done`) let the downstream receiver and the bench align their checks.

## Interface
- `HOLD`, default 2: clock cycles each symbol is held. Legal range ≥1.
- `NSYM`, default 4: symbols per frame. Legal range ≥1.
- `clk`, input, 1: rising-edge clock. The bench uses a 10 µs period.
- `rst`, input, 1: synchronous, active-high reset.
- `load`, input, 1: request to start a frame. Sampled only while `ready`=1.
- `data`, input, 2*NSYM: frame word, captured on an accepted `load`.
- `ready`, output, 1: block can accept `load`.
- `x`, output, 1: symbol bit 1, registered.
- `y`, output, 1: symbol bit 0, registered.
- `valid`, output, 1: `x`/`y` carry a frame symbol.
- `done`, output, 1: one-cycle pulse after the last symbol of a frame.

## Operation
- **States.**
  - IDLE: `ready`=1, `valid`=0, `x`=`y`=0.
  - SEND: `ready`=0, `valid`=1.
  - DONE: one cycle. `done`=1, `ready`=1, `valid`=0, `x`=`y`=0.
- **Transitions.**
  - IDLE → SEND on `load`=1.
  - SEND → DONE after the final hold cycle of symbol `NSYM-1`.
  - DONE → SEND if `load`=1.
  - DONE → IDLE otherwise.
- **Load.** `data` is copied into a `2*NSYM`-bit shift register.
- **Symbol order.** Symbol k (k=0 first) is `x`=data[2*NSYM-1-2k] and `y`=data[2*NSYM-2-2k]. The register shifts left by 2 at each symbol boundary.
- **Hold counter.** Width clog2(HOLD), minimum 1 bit. Counts 0..HOLD-1 and wraps to 0 at each symbol boundary. A symbol counter of width clog2(NSYM+1) counts symbols sent.
- **Ignored load.** `load` during SEND is ignored. The `data` change has no effect on the frame in flight.
- **Reset.**
  - On the next edge with `rst`=1, in any state (including mid-frame): state=IDLE, `ready`=1, `valid`=0, `done`=0, `x`=0, `y`=0, and all counters and the shift register are 0.
  - An aborted frame produces no `done`.
  - `rst` and `load` high on the same edge: reset wins and the load is dropped.

## Timing
- **Reset values.** `ready`=1, `valid`=0, `done`=0, `x`=0, `y`=0.
- **Load latency.** For `load` accepted at edge t:
  - Symbol 0 appears on `x`/`y` with `valid`=1 immediately after edge t.
  - `ready` drops at edge t.
- **Symbol duration.** Each symbol is stable for exactly HOLD cycles. The frame occupies NSYM*HOLD cycles (default 8 cycles = 80 µs).
- **End of frame.** At edge t+NSYM*HOLD, `valid`→0, `x`/`y`→0, and `done`→1 for exactly one cycle.
- **Back-to-back frames.** `load` sampled during the DONE cycle starts the next frame at the following edge. The minimum inter-frame gap is 1 cycle (`valid`=0).
- **HOLD=1.** The symbol changes every cycle.
- **NSYM=1.** The frame is one symbol long, then DONE.

## Test plan
- **Reset.** Assert `rst` for 2 cycles, release. Expect `ready`=1, `valid`=`done`=`x`=`y`=0 at every sampled edge.
- **Default frame.** `data`=8'b00_01_10_11, `load` pulse, HOLD=2.
  - Expect `x`/`y` = 00, 01, 10, 11, each for 2 cycles, with `valid`=1 for 8 cycles.
  - Then `done`=1 for exactly 1 cycle, then IDLE.
- **Busy load.** During SEND, pulse `load` with `data`=8'hFF. Expect the original frame to finish unchanged and only one `done`.
- **Back-to-back.** Hold `load`=1 with `data`=8'hE4, then 8'h1B.
  - Expect frames 11,10,01,00 and then 00,01,10,11.
  - Expect a single-cycle gap with `valid`=0 and `done`=1 between them.
- **Mid-frame reset.** Assert `rst` at cycle 3 of a frame.
  - Next edge: all outputs at reset values, no `done`.
  - A new `load` afterwards transmits correctly.
- **Parameter corners.** HOLD=1, NSYM=1, `data`=2'b10. Expect `x`=1, `y`=0 for 1 cycle, then `done` on the following cycle.
